// File: rtl/i2c_master_txn_seq.sv
// i2c_master_txn_seq
// Register-access sequencer above a byte-level I2C controller. Expands one
// read/write request into START/WRITE/READ/STOP byte commands, checks the
// slave ACKs, and returns the read byte plus a 2-bit error code.
// Err: 00 ok, 01 NACK, 10 arbitration lost, 11 timeout.

module i2c_master_txn_seq #(
    parameter int TO_W      = 16,
    parameter int TO_CYCLES = 5000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req,
    input  logic       i_rnw,
    input  logic [6:0] i_dev_addr,
    input  logic [7:0] i_reg_addr,
    input  logic [7:0] i_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic [1:0] o_err,
    output logic       o_byte_start,
    output logic       o_byte_stop,
    output logic       o_byte_read,
    output logic       o_byte_write,
    output logic       o_byte_tx_ack,
    output logic [7:0] o_byte_txd,
    input  logic       i_byte_done,
    input  logic       i_byte_rx_ack,
    input  logic [7:0] i_byte_rxd,
    input  logic       i_byte_al
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR_W = 3'd1;
    localparam logic [2:0] S_REG    = 3'd2;
    localparam logic [2:0] S_WDATA  = 3'd3;
    localparam logic [2:0] S_ADDR_R = 3'd4;
    localparam logic [2:0] S_RDATA  = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;
    localparam logic [2:0] S_FIN    = 3'd7;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_AL   = 2'b10;
    localparam logic [1:0] ERR_TO   = 2'b11;

    logic [2:0]      r_state;
    logic            r_issued;    // command pulse already sent in this byte state
    logic [TO_W-1:0] r_cnt;
    logic            r_err_set;   // first error of the transaction is sticky
    logic            r_rnw;
    logic [6:0]      r_dev;
    logic [7:0]      r_reg;
    logic [7:0]      r_wdata;

    logic            w_cmd_start;
    logic            w_cmd_stop;
    logic            w_cmd_read;
    logic            w_cmd_write;
    logic [7:0]      w_cmd_txd;
    logic [2:0]      w_done_next;
    logic            w_nack_err;

    // Per-state command to issue and successor state once Byte_done arrives
    always_comb begin
        w_cmd_start = 1'b0;
        w_cmd_stop  = 1'b0;
        w_cmd_read  = 1'b0;
        w_cmd_write = 1'b0;
        w_cmd_txd   = '0;
        w_done_next = S_FIN;
        w_nack_err  = 1'b0;
        case (r_state)
            S_ADDR_W: begin
                w_cmd_start = 1'b1;
                w_cmd_write = 1'b1;
                w_cmd_txd   = {r_dev, 1'b0};
                w_nack_err  = i_byte_rx_ack;
                w_done_next = i_byte_rx_ack ? S_STOP : S_REG;
            end
            S_REG: begin
                w_cmd_write = 1'b1;
                w_cmd_txd   = r_reg;
                w_nack_err  = i_byte_rx_ack;
                w_done_next = i_byte_rx_ack ? S_STOP : (r_rnw ? S_ADDR_R : S_WDATA);
            end
            S_WDATA: begin
                w_cmd_write = 1'b1;
                w_cmd_txd   = r_wdata;
                w_nack_err  = i_byte_rx_ack;
                w_done_next = S_STOP;
            end
            S_ADDR_R: begin
                w_cmd_start = 1'b1;
                w_cmd_write = 1'b1;
                w_cmd_txd   = {r_dev, 1'b1};
                w_nack_err  = i_byte_rx_ack;
                w_done_next = i_byte_rx_ack ? S_STOP : S_RDATA;
            end
            S_RDATA: begin
                w_cmd_read  = 1'b1;
                w_done_next = S_STOP;
            end
            S_STOP: begin
                w_cmd_stop  = 1'b1;
                w_done_next = S_FIN;
            end
            default: ;
        endcase
    end

    // Sequencer FSM, command pulses, timeout and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_issued      <= 1'b0;
            r_cnt         <= '0;
            r_err_set     <= 1'b0;
            r_rnw         <= 1'b0;
            r_dev         <= '0;
            r_reg         <= '0;
            r_wdata       <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_rdata       <= '0;
            o_err         <= '0;
            o_byte_start  <= 1'b0;
            o_byte_stop   <= 1'b0;
            o_byte_read   <= 1'b0;
            o_byte_write  <= 1'b0;
            o_byte_tx_ack <= 1'b1;
            o_byte_txd    <= '0;
        end else begin
            o_byte_start  <= 1'b0;
            o_byte_stop   <= 1'b0;
            o_byte_read   <= 1'b0;
            o_byte_write  <= 1'b0;
            o_byte_tx_ack <= 1'b1;
            o_done        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_rnw     <= i_rnw;
                        r_dev     <= i_dev_addr;
                        r_reg     <= i_reg_addr;
                        r_wdata   <= i_wdata;
                        o_err     <= '0;
                        r_err_set <= 1'b0;
                        r_issued  <= 1'b0;
                        o_busy    <= 1'b1;
                        r_state   <= S_ADDR_W;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    if (i_byte_al) begin
                        if (!r_err_set) begin
                            o_err     <= ERR_AL;
                            r_err_set <= 1'b1;
                        end
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= S_FIN;
                    end else if (!r_issued) begin
                        o_byte_start <= w_cmd_start;
                        o_byte_stop  <= w_cmd_stop;
                        o_byte_read  <= w_cmd_read;
                        o_byte_write <= w_cmd_write;
                        if (w_cmd_write) begin
                            o_byte_txd <= w_cmd_txd;
                        end
                        r_issued <= 1'b1;
                        r_cnt    <= '0;
                    end else if (i_byte_done) begin
                        if (w_nack_err && !r_err_set) begin
                            o_err     <= ERR_NACK;
                            r_err_set <= 1'b1;
                        end
                        if (r_state == S_RDATA) begin
                            o_rdata <= i_byte_rxd;
                        end
                        if (w_done_next == S_FIN) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end
                        r_issued <= 1'b0;
                        r_state  <= w_done_next;
                    end else if (r_cnt == TO_LAST) begin
                        if (!r_err_set) begin
                            o_err     <= ERR_TO;
                            r_err_set <= 1'b1;
                        end
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_txn_seq.sv
// Self-checking bench for i2c_master_txn_seq. The bench plays the byte
// controller / slave side; expected command sequences and results are built
// from the transaction rules (list of byte commands per access type).

module tb_i2c_master_txn_seq;

    localparam int TO = 20;

    // fault kinds applied per executed command step
    localparam int F_NONE = 0;
    localparam int F_NACK = 1;
    localparam int F_AL   = 2;
    localparam int F_TO   = 3;
    localparam int F_RST  = 4;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_req = 1'b0;
    logic       i_rnw = 1'b0;
    logic [6:0] i_dev_addr = '0;
    logic [7:0] i_reg_addr = '0;
    logic [7:0] i_wdata = '0;
    logic       o_busy, o_done;
    logic [7:0] o_rdata;
    logic [1:0] o_err;
    logic       o_byte_start, o_byte_stop, o_byte_read, o_byte_write, o_byte_tx_ack;
    logic [7:0] o_byte_txd;
    logic       i_byte_done = 1'b0;
    logic       i_byte_rx_ack = 1'b0;
    logic [7:0] i_byte_rxd = '0;
    logic       i_byte_al = 1'b0;

    i2c_master_txn_seq #(.TO_W(16), .TO_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_rnw(i_rnw),
        .i_dev_addr(i_dev_addr), .i_reg_addr(i_reg_addr), .i_wdata(i_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .o_err(o_err),
        .o_byte_start(o_byte_start), .o_byte_stop(o_byte_stop), .o_byte_read(o_byte_read),
        .o_byte_write(o_byte_write), .o_byte_tx_ack(o_byte_tx_ack), .o_byte_txd(o_byte_txd),
        .i_byte_done(i_byte_done), .i_byte_rx_ack(i_byte_rx_ack), .i_byte_rxd(i_byte_rxd),
        .i_byte_al(i_byte_al)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       st;
        bit       sp;
        bit       rd;
        bit       wr;
        bit [7:0] txd;
        bit       chk_txd;
    } cmd_t;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_rdata = '0;
    int         plan [8];
    bit         req_on_done = 1'b0;

    function automatic cmd_t mk(bit st, bit sp, bit rd, bit wr, bit [7:0] txd, bit chk);
        cmd_t c;
        c.st = st; c.sp = sp; c.rd = rd; c.wr = wr; c.txd = txd; c.chk_txd = chk;
        return c;
    endfunction

    function automatic bit any_pulse();
        return o_byte_start | o_byte_stop | o_byte_read | o_byte_write;
    endfunction

    task automatic clear_plan();
        for (int k = 0; k < 8; k++) plan[k] = F_NONE;
        req_on_done = 1'b0;
    endtask

    task automatic check_reset_vals(input string nm);
        logic [23:0] got;
        got = {o_busy, o_done, o_rdata, o_err, o_byte_start, o_byte_stop, o_byte_read,
               o_byte_write, o_byte_tx_ack, o_byte_txd};
        checks++;
        if (got !== {1'b0, 1'b0, 8'h00, 2'b00, 4'b0000, 1'b1, 8'h00}) begin
            failures++;
            $display("FAIL %s_reset_vals got=%h exp=%h", nm, got,
                     {1'b0, 1'b0, 8'h00, 2'b00, 4'b0000, 1'b1, 8'h00});
        end
    endtask

    // n idle cycles with no command pulse, no Done and Busy low
    task automatic check_quiet(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            checks++;
            if (any_pulse() || o_done || o_busy) begin
                failures++;
                $display("FAIL %s_quiet got=%b%b%b exp=000", nm, any_pulse(), o_done, o_busy);
            end
        end
    endtask

    task automatic check_final(input logic [1:0] exp_err, input string nm);
        checks++;
        if ({o_done, o_busy, o_err, o_rdata} !== {1'b1, 1'b0, exp_err, exp_rdata}) begin
            failures++;
            $display("FAIL %s_final got done=%b busy=%b err=%b rdata=%h exp done=1 busy=0 err=%b rdata=%h",
                     nm, o_done, o_busy, o_err, o_rdata, exp_err, exp_rdata);
        end
    endtask

    task automatic run_txn(input bit rnw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [7:0] rxd, input string nm);
        cmd_t       el [5];
        int         stop_idx, i, s, kind, waited, lat, n;
        logic [1:0] exp_err;
        bit         err_set, finished, aborted;
        el[0] = mk(1, 0, 0, 1, {dev, 1'b0}, 1);
        el[1] = mk(0, 0, 0, 1, rg, 1);
        if (!rnw) begin
            el[2] = mk(0, 0, 0, 1, wd, 1);
            el[3] = mk(0, 1, 0, 0, 8'h00, 0);
            stop_idx = 3;
        end else begin
            el[2] = mk(1, 0, 0, 1, {dev, 1'b1}, 1);
            el[3] = mk(0, 0, 1, 0, 8'h00, 0);
            el[4] = mk(0, 1, 0, 0, 8'h00, 0);
            stop_idx = 4;
        end
        exp_err = 2'b00; err_set = 0; finished = 0; aborted = 0; i = 0; s = 0;

        @(negedge clk);
        i_req = 1'b1; i_rnw = rnw; i_dev_addr = dev; i_reg_addr = rg; i_wdata = wd;
        @(negedge clk);
        i_req = 1'b0;
        i_rnw = 1'($urandom); i_dev_addr = 7'($urandom); i_reg_addr = 8'($urandom); i_wdata = 8'($urandom);
        checks++;
        if (o_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy_after_accept got=%b exp=1", nm, o_busy);
        end

        while (!finished) begin
            waited = 0;
            while (!any_pulse() && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            checks++;
            if (!any_pulse()) begin
                failures++;
                $display("FAIL %s_cmd%0d_wait got=none exp=command", nm, s);
                aborted = 1;
                break;
            end
            checks++;
            if ({o_byte_start, o_byte_stop, o_byte_read, o_byte_write, o_busy} !==
                {el[i].st, el[i].sp, el[i].rd, el[i].wr, 1'b1}) begin
                failures++;
                $display("FAIL %s_cmd%0d_kind got=%b%b%b%b busy=%b exp=%b%b%b%b busy=1", nm, s,
                         o_byte_start, o_byte_stop, o_byte_read, o_byte_write, o_busy,
                         el[i].st, el[i].sp, el[i].rd, el[i].wr);
            end
            if (el[i].chk_txd) begin
                checks++;
                if (o_byte_txd !== el[i].txd) begin
                    failures++;
                    $display("FAIL %s_cmd%0d_txd got=%h exp=%h", nm, s, o_byte_txd, el[i].txd);
                end
            end
            if (el[i].rd) begin
                checks++;
                if (o_byte_tx_ack !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_read_tx_ack got=%b exp=1", nm, o_byte_tx_ack);
                end
            end
            kind = plan[s];
            s++;

            if (kind == F_TO) begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                    checks++;
                    if (any_pulse()) begin
                        failures++;
                        $display("FAIL %s_to_reissue got=pulse exp=none", nm);
                    end
                end while (!o_done && n < TO + 20);
                checks++;
                if (n != TO) begin
                    failures++;
                    $display("FAIL %s_to_latency got=%0d exp=%0d", nm, n, TO);
                end
                if (!err_set) begin exp_err = 2'b11; err_set = 1; end
                check_final(exp_err, nm);
                finished = 1;
            end else if (kind == F_RST) begin
                i_rst = 1'b1;
                @(negedge clk);
                i_rst = 1'b0;
                exp_rdata = 8'h00;
                check_reset_vals(nm);
                check_quiet(4, {nm, "_after_rst"});
                aborted = 1;
                finished = 1;
            end else begin
                lat = int'($urandom_range(0, 3));
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    checks++;
                    if (any_pulse() || o_done) begin
                        failures++;
                        $display("FAIL %s_cmd%0d_spurious got=pulse%b done%b exp=00", nm, s, any_pulse(), o_done);
                    end
                end
                if (el[i].chk_txd) begin
                    checks++;
                    if (o_byte_txd !== el[i].txd) begin
                        failures++;
                        $display("FAIL %s_cmd%0d_txd_hold got=%h exp=%h", nm, s, o_byte_txd, el[i].txd);
                    end
                end
                // a Req mid-transaction with unrelated fields must be ignored
                if (s == 1) begin
                    i_req = 1'b1; i_rnw = ~rnw; i_dev_addr = ~dev; i_reg_addr = ~rg; i_wdata = ~wd;
                end
                i_byte_done   = 1'b1;
                i_byte_rx_ack = (kind == F_NACK);
                i_byte_al     = (kind == F_AL);
                i_byte_rxd    = rxd;
                @(negedge clk);
                i_byte_done = 1'b0; i_byte_rx_ack = 1'b0; i_byte_al = 1'b0; i_req = 1'b0;
                i_byte_rxd = 8'($urandom);
                if (kind == F_AL) begin
                    if (!err_set) begin exp_err = 2'b10; err_set = 1; end
                    check_final(exp_err, nm);
                    finished = 1;
                end else if (i == stop_idx) begin
                    check_final(exp_err, nm);
                    finished = 1;
                end else begin
                    checks++;
                    if (o_done !== 1'b0) begin
                        failures++;
                        $display("FAIL %s_early_done got=%b exp=0", nm, o_done);
                    end
                    if (kind == F_NACK) begin
                        if (!err_set) begin exp_err = 2'b01; err_set = 1; end
                        i = stop_idx;
                    end else begin
                        if (el[i].rd) exp_rdata = rxd;
                        i++;
                    end
                end
            end
        end

        if (!aborted) begin
            if (req_on_done) begin
                i_req = 1'b1; i_rnw = 1'b0; i_dev_addr = 7'h11;
            end
            check_quiet(1, {nm, "_done_pulse"});
            i_req = 1'b0;
            check_quiet(3, {nm, "_tail"});
        end
        clear_plan();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("rst_held");
        i_rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_released");
        exp_rdata = 8'h00;
    endtask

    task automatic test_write_basic();
        run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, "write_basic");
    endtask

    task automatic test_read_basic();
        run_txn(1'b1, 7'h50, 8'h02, 8'h00, 8'h3C, "read_basic");
    endtask

    task automatic test_nack_reg();
        plan[1] = F_NACK;
        run_txn(1'b0, 7'h50, 8'h10, 8'h77, 8'h00, "nack_reg");
    endtask

    task automatic test_al_wdata();
        plan[2] = F_AL;
        run_txn(1'b0, 7'h2B, 8'h44, 8'hC3, 8'h00, "al_wdata");
    endtask

    task automatic test_timeout();
        plan[0] = F_TO;
        run_txn(1'b0, 7'h50, 8'h01, 8'h02, 8'h00, "timeout_addr");
    endtask

    task automatic test_first_err_kept();
        plan[0] = F_NACK; plan[1] = F_AL;
        run_txn(1'b0, 7'h1A, 8'h20, 8'h30, 8'h00, "nack_then_al");
        plan[2] = F_NACK; plan[3] = F_TO;
        run_txn(1'b1, 7'h6E, 8'h05, 8'h00, 8'h99, "nack_then_to");
    endtask

    task automatic test_idle_ignore();
        @(negedge clk);
        i_byte_al = 1'b1; i_byte_done = 1'b1; i_byte_rx_ack = 1'b1;
        check_quiet(2, "idle_al_done");
        i_byte_al = 1'b0; i_byte_done = 1'b0; i_byte_rx_ack = 1'b0;
        check_quiet(1, "idle_after");
        run_txn(1'b1, 7'h3F, 8'hEE, 8'h00, 8'h5A, "after_idle_noise");
    endtask

    task automatic test_rst_mid_read();
        plan[3] = F_RST;
        run_txn(1'b1, 7'h50, 8'h02, 8'h00, 8'hD7, "rst_mid_read");
        run_txn(1'b1, 7'h50, 8'h03, 8'h00, 8'h81, "read_after_rst");
    endtask

    task automatic test_back_to_back();
        req_on_done = 1'b1;
        run_txn(1'b0, 7'h12, 8'h34, 8'h56, 8'h00, "req_on_done");
        run_txn(1'b1, 7'h12, 8'h35, 8'h00, 8'h0F, "b2b_read");
    endtask

    task automatic test_random();
        bit rnw;
        for (int t = 0; t < 24; t++) begin
            rnw = 1'($urandom);
            if ($urandom_range(0, 1) == 1) plan[$urandom_range(0, 2)] = F_NACK;
            run_txn(rnw, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), "random");
        end
    endtask

    initial begin
        clear_plan();
        test_reset();
        test_write_basic();
        test_read_basic();
        test_nack_reg();
        test_al_wdata();
        test_timeout();
        test_first_err_kept();
        test_idle_ignore();
        test_rst_mid_read();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
